// File: rtl/step_seq_pkg.sv
// step_seq_pkg: shared state type, default sizes and width helper for the one-hot step sequencer.
package step_seq_pkg;

   typedef enum logic {ST_IDLE, ST_RUN} state_t;

   localparam int SEL_W_DEF     = 4;
   localparam int NUM_STEPS_DEF = 16;

   function automatic int clog2(input int v);
      int r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/onehot_step_sequencer_bin_to_onehot.sv
// bin_to_onehot: combinational index decode; indices at or above NUM_STEPS yield all zeros.
module bin_to_onehot
   import step_seq_pkg::*;
#(
   parameter int SEL_W     = SEL_W_DEF,
   parameter int NUM_STEPS = NUM_STEPS_DEF
) (
   input  logic [SEL_W-1:0]     idx,
   output logic [NUM_STEPS-1:0] onehot
);

   for (genvar g = 0; g < NUM_STEPS; g++) begin : g_dec
      assign onehot[g] = ({1'b0, idx} == (SEL_W+1)'(g));
   end

endmodule

// File: rtl/onehot_step_sequencer.sv
// onehot_step_sequencer: registered step counter with one-hot decode, start/advance/jump/abort control.
// Optional ONEHOT_STEP_CHECK_EN adds a sticky onehot_err integrity flag.
module onehot_step_sequencer
   import step_seq_pkg::*;
#(
   parameter int SEL_W     = SEL_W_DEF,
   parameter int NUM_STEPS = NUM_STEPS_DEF,
   parameter int WRAP      = 0
) (
   input  logic                 clk,
   input  logic                 clr,
   input  logic                 start,
   input  logic                 advance,
   input  logic                 jump_en,
   input  logic [SEL_W-1:0]     jump_sel,
   input  logic                 abort,
   output logic [NUM_STEPS-1:0] step_out,
   output logic [SEL_W-1:0]     step_idx,
   output logic                 busy,
   output logic                 done,
   output logic                 range_err
`ifdef ONEHOT_STEP_CHECK_EN
   ,
   output logic                 onehot_err
`endif
);

   state_t               state, nxt_state;
   logic [SEL_W-1:0]     nxt_idx;
   logic                 nxt_done, nxt_rerr;
   logic [NUM_STEPS-1:0] dec;
   logic [SEL_W:0]       inc;
   logic                 last, jump_ok;

   // widened compare keeps the increment from aliasing through 2**SEL_W
   assign inc     = {1'b0, step_idx} + 1'b1;
   assign last    = ({1'b0, step_idx} == (SEL_W+1)'(NUM_STEPS - 1));
   assign jump_ok = ({1'b0, jump_sel} < (SEL_W+1)'(NUM_STEPS));

   always_comb begin
      nxt_state = state;
      nxt_idx   = step_idx;
      nxt_done  = 1'b0;
      nxt_rerr  = 1'b0;
      if (state == ST_IDLE) begin
         if (start) begin
            nxt_state = ST_RUN;
            nxt_idx   = '0;
         end
      end else if (abort) begin
         nxt_state = ST_IDLE;
         nxt_idx   = '0;
      end else if (jump_en) begin
         nxt_idx  = jump_ok ? jump_sel : step_idx;
         nxt_rerr = !jump_ok;
      end else if (advance) begin
         nxt_done  = last;
         nxt_idx   = last ? '0 : inc[SEL_W-1:0];
         nxt_state = (last && WRAP == 0) ? ST_IDLE : ST_RUN;
      end
   end

   bin_to_onehot #(.SEL_W(SEL_W), .NUM_STEPS(NUM_STEPS)) u_dec (
      .idx   (nxt_idx),
      .onehot(dec)
   );

   always_ff @(posedge clk) begin
      if (clr) begin
         state     <= ST_IDLE;
         step_out  <= '0;
         step_idx  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         range_err <= 1'b0;
      end else begin
         state     <= nxt_state;
         step_out  <= (nxt_state == ST_RUN) ? dec : '0;
         step_idx  <= nxt_idx;
         busy      <= (nxt_state == ST_RUN);
         done      <= nxt_done;
         range_err <= nxt_rerr;
      end
   end

`ifdef ONEHOT_STEP_CHECK_EN
   always_ff @(posedge clk) begin
      if (clr)
         onehot_err <= 1'b0;
      else if ($countones(step_out) != ((state == ST_RUN) ? 1 : 0))
         onehot_err <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_onehot_step_sequencer.sv
// tb_onehot_step_sequencer: three configurations (16/no-wrap, 16/wrap, 12/no-wrap) share stimulus; scoreboard vs. reference model.
module tb_onehot_step_sequencer;
   import step_seq_pkg::*;

   logic       clk = 0;
   logic       clr = 0, start = 0, advance = 0, jump_en = 0, abort = 0;
   logic [3:0] jump_sel = 0;

   logic [15:0] so0, so1;
   logic [11:0] so2;
   logic [3:0]  ix0, ix1, ix2;
   logic        b0, b1, b2, d0, d1, d2, r0, r1, r2;
`ifdef ONEHOT_STEP_CHECK_EN
   logic        oe0, oe1, oe2;
`endif

   int checks = 0, errors = 0;

   always #5 clk = ~clk;

   onehot_step_sequencer #(.SEL_W(4), .NUM_STEPS(16), .WRAP(0)) u0 (
      .clk(clk), .clr(clr), .start(start), .advance(advance), .jump_en(jump_en),
      .jump_sel(jump_sel), .abort(abort), .step_out(so0), .step_idx(ix0),
      .busy(b0), .done(d0), .range_err(r0)
`ifdef ONEHOT_STEP_CHECK_EN
      , .onehot_err(oe0)
`endif
   );
   onehot_step_sequencer #(.SEL_W(4), .NUM_STEPS(16), .WRAP(1)) u1 (
      .clk(clk), .clr(clr), .start(start), .advance(advance), .jump_en(jump_en),
      .jump_sel(jump_sel), .abort(abort), .step_out(so1), .step_idx(ix1),
      .busy(b1), .done(d1), .range_err(r1)
`ifdef ONEHOT_STEP_CHECK_EN
      , .onehot_err(oe1)
`endif
   );
   onehot_step_sequencer #(.SEL_W(clog2(12)), .NUM_STEPS(12), .WRAP(0)) u2 (
      .clk(clk), .clr(clr), .start(start), .advance(advance), .jump_en(jump_en),
      .jump_sel(jump_sel), .abort(abort), .step_out(so2), .step_idx(ix2),
      .busy(b2), .done(d2), .range_err(r2)
`ifdef ONEHOT_STEP_CHECK_EN
      , .onehot_err(oe2)
`endif
   );

   typedef struct { bit run; int idx; bit done; bit rerr; } mdl_t;
   typedef struct packed { logic [15:0] so; logic [3:0] idx; logic busy, done, rerr; } exp_t;

   mdl_t m0, m1, m2;
   exp_t q0[$], q1[$], q2[$];

   function automatic mdl_t model(mdl_t m, int n, bit wrap);
      mdl_t r = m;
      r.done = 0;
      r.rerr = 0;
      if (clr) begin
         r.run = 0; r.idx = 0;
      end else if (!m.run) begin
         if (start) begin r.run = 1; r.idx = 0; end
      end else if (abort) begin
         r.run = 0; r.idx = 0;
      end else if (jump_en) begin
         if (int'(jump_sel) < n) r.idx = int'(jump_sel);
         else r.rerr = 1;
      end else if (advance) begin
         if (m.idx == n - 1) begin
            r.done = 1; r.idx = 0; r.run = wrap;
         end else r.idx = m.idx + 1;
      end
      return r;
   endfunction

   function automatic exp_t mk(mdl_t m);
      exp_t e;
      e.so   = m.run ? (16'd1 << m.idx) : 16'd0;
      e.idx  = 4'(m.idx);
      e.busy = m.run;
      e.done = m.done;
      e.rerr = m.rerr;
      return e;
   endfunction

   task automatic cmp(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   task automatic chk(input string nm, input exp_t e, input logic [15:0] so, input logic [3:0] ix,
                      input logic b, input logic d, input logic r);
      cmp({nm, ".step_out"}, so, e.so);
      cmp({nm, ".step_idx"}, 16'(ix), 16'(e.idx));
      cmp({nm, ".busy"}, 16'(b), 16'(e.busy));
      cmp({nm, ".done"}, 16'(d), 16'(e.done));
      cmp({nm, ".range_err"}, 16'(r), 16'(e.rerr));
   endtask

   // monitor: outputs are presented every cycle, compared mid-cycle against queued expectations
   always @(negedge clk) begin
      if (q0.size() != 0) chk("u0", q0.pop_front(), so0, ix0, b0, d0, r0);
      if (q1.size() != 0) chk("u1", q1.pop_front(), so1, ix1, b1, d1, r1);
      if (q2.size() != 0) chk("u2", q2.pop_front(), {4'd0, so2}, ix2, b2, d2, r2);
`ifdef ONEHOT_STEP_CHECK_EN
      if (!clr) cmp("onehot_err", 16'({oe0, oe1, oe2}), 16'd0);
`endif
   end

   task automatic cyc(input bit c, input bit st, input bit adv, input bit je, input int js, input bit ab);
      clr = c; start = st; advance = adv; jump_en = je; jump_sel = 4'(js); abort = ab;
      @(posedge clk);
      m0 = model(m0, 16, 0);
      m1 = model(m1, 16, 1);
      m2 = model(m2, 12, 0);
      q0.push_back(mk(m0));
      q1.push_back(mk(m1));
      q2.push_back(mk(m2));
      #1;
   endtask

   initial begin
      m0 = '{0, 0, 0, 0};
      m1 = m0;
      m2 = m0;
      #1;
      cyc(1, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0, 0);
      repeat (15) cyc(0, 0, 1, 0, 0, 0);
      cyc(0, 0, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0, 0);
      cyc(0, 0, 1, 1, 9, 0);
      cyc(0, 0, 1, 1, 13, 0);
      cyc(0, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0, 0);
      repeat (5) cyc(0, 0, 1, 0, 0, 0);
      cyc(0, 0, 0, 1, 3, 1);
      cyc(0, 1, 0, 0, 0, 0);
      repeat (7) cyc(0, 0, 1, 0, 0, 0);
      cyc(1, 1, 1, 0, 0, 0);
      cyc(0, 1, 0, 0, 0, 0);
      repeat (4) cyc(0, 1, 1, 0, 0, 0);
      repeat (3) cyc(0, 1, 0, 0, 0, 0);
      for (int i = 0; i < 10000; i++)
         cyc($urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
             $urandom_range(0, 7) == 0, int'($urandom_range(0, 15)), $urandom_range(0, 31) == 0);
      cyc(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 10 && (q0.size() + q1.size() + q2.size()) != 0; i++) @(negedge clk);
      @(posedge clk);
      cmp("drain", 16'(q0.size() + q1.size() + q2.size()), 16'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
